// File: rtl/pll_profile_sequencer.sv
// PLL reconfiguration sequencer: debounces a requested clock profile, programs it
// through the pll_cfg management port, waits for lock and then releases the system reset.
module pll_profile_sequencer #(
  parameter int NUM_PROFILES = 4,
  parameter int PW           = 2,
  parameter int DEBOUNCE     = 2,
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRY    = 3,
  parameter int RESET_HOLD   = 100000
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [PW-1:0]             profile,
  input  logic [NUM_PROFILES*32-1:0] frac_table,
  input  logic                      pll_locked,
  input  logic                      cfg_waitrequest,
  output logic                      cfg_write,
  output logic [5:0]                cfg_address,
  output logic [31:0]               cfg_data,
  output logic                      sys_reset_n,
  output logic [PW-1:0]             cur_profile,
  output logic                      busy,
  output logic                      error
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] BOOT_LOCK = 3'd0, IDLE = 3'd1, W_MODE = 3'd2, W_FRAC = 3'd3,
                         W_START = 3'd4, WAIT_LOCK = 3'd5, HOLD = 3'd6, ERROR = 3'd7;

  logic [2:0]    state;
  logic [PW-1:0] prof_s1, prof_s2, prof_last, tgt, pend_prof, cmp_tgt;
  logic          lock_s1, lock_s2, pend_vld;
  logic [3:0]    deb_cnt;
  logic [TW-1:0] timer;
  logic [LW-1:0] lock_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] retry;
  logic [31:0]   frac_w [NUM_PROFILES];
  logic          deb_ok, in_range, req, lock_ok, timed_out, blanked;

  for (genvar k = 0; k < NUM_PROFILES; k++) begin : g_frac
    assign frac_w[k] = frac_table[32*k +: 32];
  end

  // While idle the comparison point is the live profile; otherwise the one in flight.
  assign cmp_tgt   = (state == IDLE) ? cur_profile : tgt;
  assign deb_ok    = deb_cnt >= 4'(DEBOUNCE);
  assign in_range  = {1'b0, prof_last} < (PW+1)'(NUM_PROFILES);
  assign req       = deb_ok && in_range && (prof_last != cmp_tgt);
  assign lock_ok   = lock_s2 && (lock_cnt == LW'(LOCK_STABLE - 1));
  assign timed_out = timer == TW'(LOCK_TIMEOUT);
  assign blanked   = timer < TW'(LOCK_BLANK);
  assign busy      = (state != IDLE) && (state != ERROR);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prof_s1 <= '0; prof_s2 <= '0; prof_last <= '0; deb_cnt <= '0;
      lock_s1 <= 1'b0; lock_s2 <= 1'b0;
    end else begin
      prof_s1 <= profile; prof_s2 <= prof_s1;
      lock_s1 <= pll_locked; lock_s2 <= lock_s1;
      if (prof_s2 != prof_last) begin
        prof_last <= prof_s2;
        deb_cnt   <= 4'd1;
      end else if (!deb_ok) begin
        deb_cnt <= deb_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT_LOCK; cfg_write <= 1'b0; cfg_address <= '0; cfg_data <= '0;
      sys_reset_n <= 1'b0; cur_profile <= '0; error <= 1'b0;
      tgt <= '0; pend_prof <= '0; pend_vld <= 1'b0;
      timer <= '0; lock_cnt <= '0; hold_cnt <= '0; retry <= '0;
    end else begin
      if ((state == BOOT_LOCK || state == WAIT_LOCK) && !timed_out) timer <= timer + 1'b1;
      if (state == BOOT_LOCK || (state == WAIT_LOCK && !blanked))
        lock_cnt <= !lock_s2 ? '0 : (lock_ok ? lock_cnt : lock_cnt + 1'b1);
      // Requests arriving while a write is in flight are parked until the start write lands.
      if ((state == W_MODE || state == W_FRAC || state == W_START) && req) begin
        pend_vld  <= 1'b1;
        pend_prof <= prof_last;
        retry     <= '0;
      end
      case (state)
        BOOT_LOCK: begin
          if (lock_ok) begin
            state <= HOLD; hold_cnt <= '0;
          end else if (timed_out) begin
            state <= ERROR; error <= 1'b1;
          end
        end
        IDLE: begin
          sys_reset_n <= 1'b1;
          if (req) begin
            tgt <= prof_last; retry <= '0; pend_vld <= 1'b0;
            sys_reset_n <= 1'b0; state <= W_MODE;
          end
        end
        W_MODE: begin
          if (!cfg_write) begin
            cfg_write <= 1'b1; cfg_address <= 6'd0; cfg_data <= '0;
          end else if (!cfg_waitrequest) begin
            cfg_write <= 1'b0; state <= W_FRAC;
          end
        end
        W_FRAC: begin
          if (!cfg_write) begin
            cfg_write <= 1'b1; cfg_address <= 6'd7; cfg_data <= frac_w[tgt];
          end else if (!cfg_waitrequest) begin
            cfg_write <= 1'b0; state <= W_START;
          end
        end
        W_START: begin
          if (!cfg_write) begin
            cfg_write <= 1'b1; cfg_address <= 6'd2; cfg_data <= '0;
          end else if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            if (pend_vld || req) begin
              tgt <= req ? prof_last : pend_prof;
              pend_vld <= 1'b0; retry <= '0; state <= W_MODE;
            end else begin
              timer <= '0; lock_cnt <= '0; state <= WAIT_LOCK;
            end
          end
        end
        WAIT_LOCK: begin
          if (req) begin
            tgt <= prof_last; retry <= '0; pend_vld <= 1'b0; state <= W_MODE;
          end else if (lock_ok && !blanked) begin
            cur_profile <= tgt; hold_cnt <= '0; state <= HOLD;
          end else if (timed_out) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1; state <= W_MODE;
            end else begin
              error <= 1'b1; state <= ERROR;
            end
          end
        end
        HOLD: begin
          if (req) begin
            tgt <= prof_last; retry <= '0; pend_vld <= 1'b0;
            sys_reset_n <= 1'b0; state <= W_MODE;
          end else if (!lock_s2) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(RESET_HOLD - 1)) begin
            sys_reset_n <= 1'b1; state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ERROR: begin
          sys_reset_n <= 1'b0;
          if (req) begin
            error <= 1'b0; tgt <= prof_last; retry <= '0; pend_vld <= 1'b0;
            state <= W_MODE;
          end
        end
        default: state <= BOOT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_profile_sequencer.sv
// Scoreboard bench for pll_profile_sequencer: expected mgmt writes are queued with each
// profile request and checked as the DUT's writes are accepted.
module tb_pll_profile_sequencer;
  localparam int NP = 4, PW = 2, DEB = 2, LB = 4, LS = 8, LT = 100, MR = 3, RH = 20;

  logic              clk_sys = 1'b0, reset_n = 1'b0, pll_locked = 1'b0;
  logic [PW-1:0]     profile = '0;
  logic [NP*32-1:0]  frac_table;
  logic              cfg_waitrequest, cfg_write, sys_reset_n, busy, error;
  logic [5:0]        cfg_address;
  logic [31:0]       cfg_data;
  logic [PW-1:0]     cur_profile;

  pll_profile_sequencer #(.NUM_PROFILES(NP), .PW(PW), .DEBOUNCE(DEB), .LOCK_BLANK(LB),
    .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .RESET_HOLD(RH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .profile(profile), .frac_table(frac_table),
    .pll_locked(pll_locked), .cfg_waitrequest(cfg_waitrequest), .cfg_write(cfg_write),
    .cfg_address(cfg_address), .cfg_data(cfg_data), .sys_reset_n(sys_reset_n),
    .cur_profile(cur_profile), .busy(busy), .error(error));

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q [$];
  logic [31:0] fr [NP];
  int n_chk = 0, n_err = 0, n_acc = 0, n_stall = 0, cyc = 0;
  int stall_cfg = 0, stall_used = 0, t6_gap = -1, last_cyc = 0;
  logic [5:0] last_a = 6'h3f;
  logic t6_on = 1'b0, saw_one = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #2; end
  endtask

  task automatic push_trip(input int p);
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd7, fr[p]});
    exp_q.push_back({6'd2, 32'd0});
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (!busy && k < 100) begin tick(1); k++; end
    chk(tag, busy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || !sys_reset_n) && k < 3000) begin tick(1); k++; end
    chk(tag, {busy, sys_reset_n}, 2'b01);
  endtask

  // Bench-side slave: stalls the addr-7 write until stall_cfg stall cycles have been spent.
  assign cfg_waitrequest = cfg_write && (cfg_address == 6'd7) && (stall_used < stall_cfg);
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (cfg_waitrequest) stall_used <= stall_used + 1;
  end

  logic prv_stall = 1'b0;
  logic [5:0] prv_a;
  logic [31:0] prv_d;
  always @(negedge clk_sys) begin
    wr_t e;
    if (reset_n) begin
      if (prv_stall) begin
        chk("stall_hold_write", cfg_write, 1);
        chk("stall_hold_addr", cfg_address, prv_a);
        chk("stall_hold_data", cfg_data, prv_d);
      end
      prv_stall = cfg_write && cfg_waitrequest;
      prv_a = cfg_address; prv_d = cfg_data;
      if (cfg_write && cfg_waitrequest) n_stall++;
      if (cfg_write && !cfg_waitrequest) begin
        n_acc++;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", cfg_address, e.a);
          chk("wr_data", cfg_data, e.d);
        end
        if (cfg_address == 6'd0) chk("sysrst_low_at_write", sys_reset_n, 0);
        if (t6_on && cfg_address == 6'd0 && last_a == 6'd2) t6_gap = cyc - last_cyc;
        last_a = cfg_address; last_cyc = cyc;
      end
      if (t6_on && cur_profile == 2'd1) saw_one = 1'b1;
    end
  end

  initial begin
    int k, a0;
    fr[0] = 32'h1111_0000; fr[1] = 32'h2222_0001; fr[2] = 32'd3357876127; fr[3] = 32'h4444_0003;
    frac_table = {fr[3], fr[2], fr[1], fr[0]};

    // 1: boot
    tick(3);
    chk("rst_cfg_write", cfg_write, 0);
    chk("rst_cfg_address", cfg_address, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_sys_reset_n", sys_reset_n, 0);
    chk("rst_cur_profile", cur_profile, 0);
    chk("rst_busy", busy, 1);
    chk("rst_error", error, 0);
    reset_n = 1'b1;
    tick(10);
    pll_locked = 1'b1;
    k = 10;
    while (!sys_reset_n && k < 500) begin tick(1); k++; end
    chk("boot_release_cycle", k, 10 + 2 + LS + RH);
    chk("boot_busy", busy, 0);
    chk("boot_no_writes", n_acc, 0);

    // 2: program profile 2
    push_trip(2);
    profile = 2'd2;
    k = 0;
    while (cur_profile != 2'd2 && k < 500) begin tick(1); k++; end
    chk("t2_cur_profile", cur_profile, 2);
    k = 0;
    while (!sys_reset_n && k < 500) begin tick(1); k++; end
    chk("t2_hold_len", k, RH);
    chk("t2_busy", busy, 0);
    chk("t2_writes", n_acc, 3);
    chk("t2_queue_empty", exp_q.size(), 0);

    // 3: waitrequest stall on the frac write
    a0 = n_acc; stall_cfg = 5;
    push_trip(1);
    profile = 2'd1;
    wait_busy("t3_busy");
    wait_idle("t3_idle");
    chk("t3_stall_cycles", n_stall, 5);
    chk("t3_writes", n_acc - a0, 3);
    chk("t3_cur_profile", cur_profile, 1);

    // 4: debounce
    a0 = n_acc;
    profile = 2'd3; tick(1); profile = 2'd1;
    tick(12);
    chk("t4_glitch_no_write", n_acc - a0, 0);
    chk("t4_glitch_busy", busy, 0);
    push_trip(3);
    profile = 2'd3;
    wait_busy("t4_busy");
    wait_idle("t4_idle");
    chk("t4_cur_profile", cur_profile, 3);
    chk("t4_writes", n_acc - a0, 3);

    // 5: lock never comes
    a0 = n_acc;
    pll_locked = 1'b0;
    for (int i = 0; i < MR + 1; i++) push_trip(0);
    profile = 2'd0;
    k = 0;
    while (!error && k < 3000) begin tick(1); k++; end
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 0);
    chk("t5_sys_reset_n", sys_reset_n, 0);
    chk("t5_writes", n_acc - a0, 12);
    chk("t5_cur_profile", cur_profile, 3);
    push_trip(1);
    pll_locked = 1'b1;
    profile = 2'd1;
    wait_busy("t5_recover_busy");
    chk("t5_error_cleared", error, 0);
    wait_idle("t5_recover_idle");
    chk("t5_recover_profile", cur_profile, 1);

    push_trip(0);
    profile = 2'd0;
    wait_busy("t6_prep_busy");
    wait_idle("t6_prep_idle");
    chk("t6_prep_profile", cur_profile, 0);

    // 6: request change during the frac write
    a0 = n_acc; stall_cfg = stall_used + 8;
    t6_on = 1'b1; saw_one = 1'b0;
    push_trip(1);
    profile = 2'd1;
    k = 0;
    while (!(cfg_write && cfg_address == 6'd7) && k < 100) begin tick(1); k++; end
    chk("t6_frac_write_seen", cfg_write && cfg_address == 6'd7, 1);
    push_trip(3);
    profile = 2'd3;
    wait_idle("t6_idle");
    t6_on = 1'b0;
    chk("t6_cur_profile", cur_profile, 3);
    chk("t6_never_one", saw_one, 0);
    chk("t6_restart_gap", t6_gap, 2);
    chk("t6_writes", n_acc - a0, 6);
    chk("t6_queue_empty", exp_q.size(), 0);

    // async reset in the middle of a sequence
    exp_q.push_back({6'd0, 32'd0});
    profile = 2'd2;
    k = 0;
    while (!(cfg_write && cfg_address == 6'd7) && k < 100) begin tick(1); k++; end
    chk("rst_mid_data", cfg_data, fr[2]);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cfg_write", cfg_write, 0);
    chk("rst_mid_cfg_address", cfg_address, 0);
    chk("rst_mid_cfg_data", cfg_data, 0);
    chk("rst_mid_sys_reset_n", sys_reset_n, 0);
    chk("rst_mid_cur_profile", cur_profile, 0);
    chk("rst_mid_busy", busy, 1);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_queue_empty", exp_q.size(), 0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
